// File: rtl/ctrl_pwm_mc_if.sv
// Control bundle for ctrl_pwm_mc: button levels, step mode and channel select in,
// packed duty registers and limit flags out.
interface ctrl_pwm_mc_if #(
  parameter int CH   = 4,
  parameter int SELW = 2,
  parameter int W    = 7
) ();
  logic            ena;
  logic            xu;
  logic            xd;
  logic            fine;
  logic [SELW-1:0] ch_sel;
  logic [CH*W-1:0] duty;
  logic            at_max;
  logic            at_min;

  modport master (
    output ena, xu, xd, fine, ch_sel,
    input  duty, at_max, at_min
  );

  modport slave (
    input  ena, xu, xd, fine, ch_sel,
    output duty, at_max, at_min
  );
endinterface

// File: rtl/ctrl_pwm_mc.sv
// Multi-channel saturating duty controller driven by up/down buttons, with
// coarse/fine steps and press-and-hold auto-repeat on a latched channel.
module ctrl_pwm_mc #(
  parameter int CH       = 4,
  parameter int SELW     = 2,
  parameter int W        = 7,
  parameter int DMAX     = 100,
  parameter int STEP     = 10,
  parameter int RST_DUTY = 0,
  parameter int HOLD_CYC = 5000000,
  parameter int REP_CYC  = 1000000
) (
  input  logic         clk,
  input  logic         rst,
  ctrl_pwm_mc_if.slave bus
);

  localparam int CMAX = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
  localparam int CNTW = $clog2(CMAX) + 1;
  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD_CYC - 1);
  localparam logic [CNTW-1:0] REP_LAST  = CNTW'(REP_CYC - 1);
  localparam logic [W:0]      DMAX_X    = (W+1)'(DMAX);
  localparam logic [W:0]      STEP_X    = (W+1)'(STEP);
  localparam logic [W:0]      ONE_X     = (W+1)'(1);
  localparam logic [W-1:0]    RST_V     = W'(RST_DUTY);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_t;

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [SELW-1:0] ch_q, ch_d;
  logic            dir_q, dir_d;
  logic            xu_q, xu_d;
  logic            xd_q, xd_d;
  logic [W-1:0]    duty_q [CH];
  logic [W-1:0]    duty_d [CH];

  logic            press;
  logic            held;
  logic            both;
  logic            ch_ok;
  logic            step_en;
  logic            step_up;
  logic [SELW-1:0] step_ch;
  logic [W-1:0]    cur;
  logic [W-1:0]    nxt;
  logic [W:0]      cur_x;
  logic [W:0]      s_x;
  logic [W:0]      sum_x;
  logic [W:0]      dif_x;
  logic [W-1:0]    sel_duty;
  logic            sel_ok;

  // A press is a fresh rising edge on exactly one button; held tracks the latched direction.
  always_comb begin
    both  = bus.xu & bus.xd;
    press = ((bus.xu & ~xu_q) ^ (bus.xd & ~xd_q)) & (bus.xu ^ bus.xd);
    held  = dir_q ? (bus.xu & ~bus.xd) : (bus.xd & ~bus.xu);
    ch_ok = 1'b0;
    for (int k = 0; k < CH; k++) begin
      if (bus.ch_sel == SELW'(k)) ch_ok = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    dir_d   = dir_q;
    xu_d    = xu_q;
    xd_d    = xd_q;
    step_en = 1'b0;
    step_ch = ch_q;
    step_up = dir_q;
    if (bus.ena) begin
      xu_d = bus.xu;
      xd_d = bus.xd;
      if (both) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (press && ch_ok) begin
              step_en = 1'b1;
              step_ch = bus.ch_sel;
              step_up = bus.xu;
              ch_d    = bus.ch_sel;
              dir_d   = bus.xu;
              cnt_d   = '0;
              state_d = HOLD;
            end
          end
          HOLD: begin
            if (!held) begin
              state_d = IDLE;
            end else if (cnt_q == HOLD_LAST) begin
              step_en = 1'b1;
              cnt_d   = '0;
              state_d = REPEAT;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          REPEAT: begin
            if (!held) begin
              state_d = IDLE;
            end else if (cnt_q == REP_LAST) begin
              step_en = 1'b1;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Saturating step evaluated one bit wider than the register so neither limit can wrap.
  always_comb begin
    cur = '0;
    for (int k = 0; k < CH; k++) begin
      if (step_ch == SELW'(k)) cur = duty_q[k];
    end
    cur_x = {1'b0, cur};
    s_x   = bus.fine ? ONE_X : STEP_X;
    sum_x = cur_x + s_x;
    dif_x = cur_x - s_x;
    if (step_up) begin
      nxt = (cur_x >= DMAX_X - s_x) ? DMAX_X[W-1:0] : sum_x[W-1:0];
    end else begin
      nxt = (cur_x <= s_x) ? '0 : dif_x[W-1:0];
    end
    for (int k = 0; k < CH; k++) begin
      duty_d[k] = duty_q[k];
      if (step_en && (step_ch == SELW'(k))) duty_d[k] = nxt;
    end
  end

  always_comb begin
    sel_duty = '0;
    sel_ok   = 1'b0;
    for (int k = 0; k < CH; k++) begin
      if (bus.ch_sel == SELW'(k)) begin
        sel_duty = duty_q[k];
        sel_ok   = 1'b1;
      end
    end
    bus.at_max = sel_ok && (sel_duty == DMAX_X[W-1:0]);
    bus.at_min = sel_ok && (sel_duty == '0);
    for (int k = 0; k < CH; k++) begin
      bus.duty[k*W +: W] = duty_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      dir_q   <= 1'b0;
      xu_q    <= 1'b0;
      xd_q    <= 1'b0;
      for (int k = 0; k < CH; k++) duty_q[k] <= RST_V;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      dir_q   <= dir_d;
      xu_q    <= xu_d;
      xd_q    <= xd_d;
      for (int k = 0; k < CH; k++) duty_q[k] <= duty_d[k];
    end
  end

endmodule

// File: tb/tb_ctrl_pwm_mc.sv
// Directed bench for ctrl_pwm_mc with a cycle-level behavioural model and
// hand-computed checkpoints; uses short hold/repeat periods (8/4).
module tb_ctrl_pwm_mc;

  localparam int CH   = 4;
  localparam int SELW = 2;
  localparam int W    = 7;
  localparam int DMAX = 100;
  localparam int STEP = 10;
  localparam int HOLD = 8;
  localparam int REP  = 4;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  // Behavioural model state: per-channel duty plus "cycles held since press".
  int   m_duty [CH];
  bit   m_active;
  bit   m_dir;
  int   m_ch;
  int   m_n;
  bit   m_pu;
  bit   m_pd;

  ctrl_pwm_mc_if #(.CH(CH), .SELW(SELW), .W(W)) bus ();

  ctrl_pwm_mc #(
    .CH(CH), .SELW(SELW), .W(W), .DMAX(DMAX), .STEP(STEP), .RST_DUTY(0),
    .HOLD_CYC(HOLD), .REP_CYC(REP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  function automatic int stepVal(input int d, input bit up, input bit f);
    int s;
    s = f ? 1 : STEP;
    if (up) return (d + s > DMAX) ? DMAX : d + s;
    return (d - s < 0) ? 0 : d - s;
  endfunction

  function automatic int dutyOf(input int k);
    return int'(bus.duty[k*W +: W]);
  endfunction

  task automatic checkOutput(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Inputs change on the falling edge; each cycle waited is one rising edge sampled.
  task automatic applyStimulus(input bit u, input bit d, input bit f, input int ch, input int cycles);
    bus.xu     = u;
    bus.xd     = d;
    bus.fine   = f;
    bus.ch_sel = SELW'(ch);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic pressOnce(input bit up, input int ch, input bit f);
    applyStimulus(up, !up, f, ch, 1);
    applyStimulus(1'b0, 1'b0, f, ch, 1);
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int k = 0; k < CH; k++) m_duty[k] = 0;
        m_active = 0; m_dir = 0; m_ch = 0; m_n = 0; m_pu = 0; m_pd = 0;
      end else if (bus.ena) begin
        if (bus.xu && bus.xd) begin
          m_active = 0;
        end else if (m_active) begin
          if (m_dir ? (bus.xu && !bus.xd) : (bus.xd && !bus.xu)) begin
            m_n++;
            if (m_n == HOLD || (m_n > HOLD && (m_n - HOLD) % REP == 0))
              m_duty[m_ch] = stepVal(m_duty[m_ch], m_dir, bus.fine);
          end else begin
            m_active = 0;
          end
        end else if (((bus.xu && !m_pu) != (bus.xd && !m_pd)) && (bus.xu != bus.xd)
                     && int'(bus.ch_sel) < CH) begin
          m_ch         = int'(bus.ch_sel);
          m_dir        = bus.xu;
          m_n          = 0;
          m_active     = 1;
          m_duty[m_ch] = stepVal(m_duty[m_ch], m_dir, bus.fine);
        end
        m_pu = bus.xu;
        m_pd = bus.xd;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (rst) begin
        for (int k = 0; k < CH; k++)
          checkOutput($sformatf("model_duty%0d", k), dutyOf(k), m_duty[k]);
        checkOutput("model_at_max", int'(bus.at_max), int'(m_duty[int'(bus.ch_sel)] == DMAX));
        checkOutput("model_at_min", int'(bus.at_min), int'(m_duty[int'(bus.ch_sel)] == 0));
      end
    end
  end

  initial begin
    #200000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    int up_exp [6];
    up_exp = '{96, 97, 98, 99, 100, 100};
    rst        = 1'b0;
    bus.ena    = 1'b1;
    bus.xu     = 1'b0;
    bus.xd     = 1'b0;
    bus.fine   = 1'b0;
    bus.ch_sel = '0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < CH; k++) checkOutput($sformatf("reset_duty%0d", k), dutyOf(k), 0);
    checkOutput("reset_at_min", int'(bus.at_min), 1);
    checkOutput("reset_at_max", int'(bus.at_max), 0);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] async reset mid-hold");
    pressOnce(1'b1, 0, 1'b0);
    pressOnce(1'b1, 0, 1'b0);
    checkOutput("pre_reset_ch0", dutyOf(0), 20);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 2);
    checkOutput("hold_ch0", dutyOf(0), 30);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("async_ch0", dutyOf(0), 0);
    checkOutput("async_at_min", int'(bus.at_min), 1);
    checkOutput("async_at_max", int'(bus.at_max), 0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 2);
    rst = 1'b1;
    @(negedge clk);
    pressOnce(1'b1, 2, 1'b0);
    checkOutput("after_reset_ch2", dutyOf(2), 10);
    checkOutput("after_reset_ch0", dutyOf(0), 0);

    $display("[TB] saturation");
    for (int i = 1; i <= 11; i++) begin
      pressOnce(1'b1, 0, 1'b0);
      checkOutput($sformatf("sat_up%0d", i), dutyOf(0), (i * 10 > 100) ? 100 : i * 10);
    end
    checkOutput("sat_at_max", int'(bus.at_max), 1);
    for (int i = 1; i <= 11; i++) begin
      pressOnce(1'b0, 0, 1'b0);
      checkOutput($sformatf("sat_dn%0d", i), dutyOf(0), (100 - i * 10 < 0) ? 0 : 100 - i * 10);
    end
    checkOutput("sat_at_min", int'(bus.at_min), 1);

    $display("[TB] fine mode");
    repeat (9) pressOnce(1'b1, 1, 1'b0);
    repeat (5) pressOnce(1'b1, 1, 1'b1);
    checkOutput("fine_start", dutyOf(1), 95);
    for (int i = 0; i < 6; i++) begin
      pressOnce(1'b1, 1, 1'b1);
      checkOutput($sformatf("fine_up%0d", i), dutyOf(1), up_exp[i]);
    end
    repeat (5) pressOnce(1'b0, 1, 1'b1);
    checkOutput("fine_back", dutyOf(1), 95);
    pressOnce(1'b1, 1, 1'b0);
    checkOutput("coarse_clip", dutyOf(1), 100);

    $display("[TB] auto-repeat");
    applyStimulus(1'b1, 1'b0, 1'b0, 3, 9);
    checkOutput("rep_after9", dutyOf(3), 20);
    applyStimulus(1'b1, 1'b0, 1'b0, 3, 11);
    checkOutput("rep_after20", dutyOf(3), 40);
    applyStimulus(1'b0, 1'b0, 1'b0, 3, 10);
    checkOutput("rep_released", dutyOf(3), 40);

    $display("[TB] latched channel");
    applyStimulus(1'b0, 1'b1, 1'b0, 3, 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1, 8);
    checkOutput("latch_ch3", dutyOf(3), 20);
    checkOutput("latch_ch1", dutyOf(1), 100);
    applyStimulus(1'b0, 1'b0, 1'b0, 3, 2);

    $display("[TB] button conflict");
    applyStimulus(1'b1, 1'b0, 1'b0, 2, 3);
    checkOutput("conf_press", dutyOf(2), 20);
    applyStimulus(1'b1, 1'b1, 1'b0, 2, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 2, 12);
    checkOutput("conf_no_step", dutyOf(2), 20);
    applyStimulus(1'b0, 1'b0, 1'b0, 2, 2);

    $display("[TB] enable");
    applyStimulus(1'b1, 1'b0, 1'b0, 2, 3);
    checkOutput("ena_press", dutyOf(2), 30);
    bus.ena = 1'b0;
    repeat (5) @(negedge clk);
    bus.ena = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("ena_before", dutyOf(2), 30);
    @(negedge clk);
    checkOutput("ena_delayed", dutyOf(2), 40);
    applyStimulus(1'b0, 1'b0, 1'b0, 2, 2);
    bus.ena = 1'b0;
    repeat (3) pressOnce(1'b1, 2, 1'b0);
    bus.ena = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 2, 2);
    checkOutput("ena_ignored", dutyOf(2), 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
